// File: rtl/seq_divider_16bit.sv
// Iterative unsigned restoring divider: one trial subtraction per cycle, WIDTH cycles per result.
// Divide-by-zero short-circuits to the DONE state with an all-ones quotient and the dividend as remainder.
module seq_divider_16bit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             DivZero,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH:0]    rem_q, rem_d;      // working remainder, one guard bit
   logic [WIDTH-1:0]  acc_q, acc_d;      // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0]  dsr_q, dsr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0]  quotient_q, quotient_d;
   logic [WIDTH-1:0]  remainder_q, remainder_d;
   logic              div_zero_q, div_zero_d;
   logic              done_q, done_d;

   logic [WIDTH:0]    shifted;
   logic [WIDTH:0]    trial;
   logic [WIDTH:0]    step_rem;
   logic [WIDTH-1:0]  step_acc;

   // One restoring step: a negative trial (guard bit set) keeps the shifted remainder.
   always_comb begin
      shifted  = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
      trial    = shifted - {1'b0, dsr_q};
      step_rem = trial[WIDTH] ? shifted : trial;
      step_acc = {acc_q[WIDTH-2:0], ~trial[WIDTH]};
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      acc_d       = acc_q;
      dsr_d       = dsr_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      div_zero_d  = div_zero_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               rem_d = '0;
               cnt_d = '0;
               acc_d = Dividend;
               dsr_d = Divisor;
               if (Divisor == '0) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  quotient_d  = '1;
                  remainder_d = Dividend;
                  div_zero_d  = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            rem_d = step_rem;
            acc_d = step_acc;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               quotient_d  = step_acc;
               remainder_d = step_rem[WIDTH-1:0];
               div_zero_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         acc_q       <= '0;
         dsr_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         acc_q       <= acc_d;
         dsr_q       <= dsr_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         div_zero_q  <= div_zero_d;
         done_q      <= done_d;
      end
   end

   assign Quotient  = quotient_q;
   assign Remainder = remainder_q;
   assign DivZero   = div_zero_q;
   assign busy      = (state_q == S_RUN);
   assign done      = done_q;

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Self-checking bench for seq_divider_16bit: directed cases plus randomized operands
// compared against plain integer division.
module tb_seq_divider_16bit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] Dividend;
   logic [15:0] Divisor;
   logic [15:0] Quotient;
   logic [15:0] Remainder;
   logic        DivZero;
   logic        busy;
   logic        done;

   int n_tests = 0;
   int n_fail  = 0;
   logic [15:0] prev_q = 16'd0;
   logic [15:0] prev_r = 16'd0;

   seq_divider_16bit #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivZero   (DivZero),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", tag, got, exp);
      end
   endtask

   // Caller is #1 after a rising edge; returns #1 after the edge that raised done.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b);
      int          cyc;
      logic [15:0] eq, er;
      logic        ez;
      if (b == 16'd0) begin
         eq = 16'hFFFF; er = a; ez = 1'b1;
      end else begin
         eq = a / b; er = a % b; ez = 1'b0;
      end
      start = 1'b1; Dividend = a; Divisor = b;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      while (!done && cyc < 40) begin
         if (cyc == 5) begin
            check("held_quotient", 32'(Quotient), 32'(prev_q));
            check("held_remainder", 32'(Remainder), 32'(prev_r));
            check("busy_in_run", 32'(busy), 32'd1);
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", 32'(cyc), (b == 16'd0) ? 32'd1 : 32'd17);
      check("quotient", 32'(Quotient), 32'(eq));
      check("remainder", 32'(Remainder), 32'(er));
      check("divzero", 32'(DivZero), 32'(ez));
      if (!ez)
         check("invariant", 32'(Quotient) * 32'(b) + 32'(Remainder), 32'(a));
      prev_q = eq;
      prev_r = er;
      $display("[TB] %0d / %0d -> q=%0d r=%0d dz=%0b (cycle %0d)", a, b, Quotient, Remainder, DivZero, cyc);
   endtask

   initial begin
      int   cyc;
      bit   seen_done;
      logic [15:0] a, b;

      rst = 1'b1; start = 1'b0; Dividend = '0; Divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_quotient", 32'(Quotient), 32'd0);
      check("rst_remainder", 32'(Remainder), 32'd0);
      check("rst_divzero", 32'(DivZero), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: 100/7, then done must drop and the result must hold
      run_op(16'd100, 16'd7);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("hold_after_done", 32'(Quotient), 32'd14);

      // 2, 3: boundaries and divide by zero
      run_op(16'hFFFF, 16'h0001);
      @(posedge clk); #1;
      run_op(16'hFFFF, 16'hFFFF);
      @(posedge clk); #1;
      run_op(16'd5, 16'd9);
      @(posedge clk); #1;
      run_op(16'h1234, 16'h0000);
      @(posedge clk); #1;

      // 4: start while busy is ignored, including the operand change
      start = 1'b1; Dividend = 16'd100; Divisor = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1;
      repeat (3) begin @(posedge clk); #1; cyc++; end
      start = 1'b1; Dividend = 16'd50; Divisor = 16'd5;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
      check("busy_start_latency", 32'(cyc), 32'd17);
      check("busy_start_quotient", 32'(Quotient), 32'd14);
      check("busy_start_remainder", 32'(Remainder), 32'd2);
      $display("[TB] 100 / 7 with ignored start -> q=%0d r=%0d (cycle %0d)", Quotient, Remainder, cyc);
      @(posedge clk); #1;

      // 5: async reset mid-operation discards it
      start = 1'b1; Dividend = 16'd1000; Divisor = 16'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("midrst_quotient", 32'(Quotient), 32'd0);
      check("midrst_remainder", 32'(Remainder), 32'd0);
      check("midrst_divzero", 32'(DivZero), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      prev_q = 16'd0; prev_r = 16'd0;
      seen_done = 1'b0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) seen_done = 1'b1;
      end
      check("no_done_after_rst", 32'(seen_done), 32'd0);
      $display("[TB] 1000 / 3 aborted by reset");
      run_op(16'd9, 16'd2);
      @(posedge clk); #1;

      // 6: back-to-back start on the done cycle
      run_op(16'd200, 16'd9);
      run_op(16'd77, 16'd10);
      run_op(16'h0042, 16'h0000);
      run_op(16'd500, 16'd0);
      run_op(16'd1234, 16'd56);

      // Random operands with occasional zero divisors and idle gaps
      for (int i = 0; i < 2000; i++) begin
         a = 16'($urandom);
         case ($urandom_range(0, 15))
            0:       b = 16'd0;
            1, 2:    b = 16'($urandom_range(1, 15));
            default: b = 16'($urandom);
         endcase
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         run_op(a, b);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
